// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer and its output buffer.
package fetch_sequencer_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
  } fetch_out_t;

  // Redirect targets are halfword aligned; bit 0 never reaches the bus.
  function automatic logic [63:0] align_target(input logic [63:0] target);
    return target & ~64'd1;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry output buffer plus one-entry skid between the instruction bus and decode.
module fetch_skid_buf
  import fetch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  logic [63:0] push_pc,
  input  logic [31:0] push_instr,
  input  logic        out_ready,
  output fetch_out_t  head,
  output logic        skid_valid
);

  fetch_out_t head_q;
  fetch_out_t skid_q;
  fetch_out_t push_entry;
  logic       pop;

  assign pop        = head_q.valid & out_ready;
  assign push_entry = '{pc: push_pc, instr: push_instr, valid: 1'b1};
  assign head       = head_q;
  assign skid_valid = skid_q.valid;

  // A full skid drains into the head before any new response is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      head_q.valid <= 1'b0;
      skid_q.valid <= 1'b0;
    end else if (skid_q.valid) begin
      if (pop) begin
        head_q       <= skid_q;
        skid_q.valid <= 1'b0;
      end
    end else if (push) begin
      if (!head_q.valid || pop) begin
        head_q <= push_entry;
      end else begin
        skid_q <= push_entry;
      end
    end else if (pop) begin
      head_q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: issues instruction-bus requests, absorbs redirects, feeds decode.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        csr_flush,
  input  logic [63:0] csr_pc,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  fetch_state_t state;
  logic [63:0]  pc;
  logic [63:0]  pc_req;
  logic         redirect;
  logic [63:0]  target;
  logic         push;
  logic         skid_valid;
  fetch_out_t   head;

  assign redirect   = csr_flush | redirect_valid;
  assign target     = align_target(csr_flush ? csr_pc : redirect_pc);
  assign push       = (state == REQ) & iresp_ok & ~redirect;

  assign ireq_valid = (state == REQ) || (state == KILL);
  assign ireq_addr  = pc_req;

  assign out_valid  = head.valid;
  assign out_pc     = head.pc;
  assign out_instr  = head.instr;

  // pc_req only moves when a response lands or no request is on the bus,
  // so the address stays frozen across memory latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      pc_req <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          state  <= REQ;
          pc_req <= pc;
        end
        REQ: begin
          if (redirect) begin
            pc <= target;
            if (iresp_ok) begin
              pc_req <= target;
            end else begin
              state <= KILL;
            end
          end else if (iresp_ok) begin
            pc     <= pc + 64'd4;
            pc_req <= pc + 64'd4;
            if (head.valid && !out_ready) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc     <= target;
            pc_req <= target;
            state  <= REQ;
          end else if (out_ready) begin
            pc_req <= pc;
            state  <= REQ;
          end
        end
        KILL: begin
          if (redirect) begin
            pc <= target;
          end
          if (iresp_ok) begin
            pc_req <= redirect ? target : pc;
            state  <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_skid_buf u_skid_buf (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (push),
    .push_pc    (pc_req),
    .push_instr (iresp_data),
    .out_ready  (out_ready),
    .head       (head),
    .skid_valid (skid_valid)
  );

  logic unused_ok;
  assign unused_ok = skid_valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        csr_flush;
  logic [63:0] csr_pc;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  int pass_count;
  int check_count;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_ok       (iresp_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .csr_flush      (csr_flush),
    .csr_pc         (csr_pc),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The memory model returns a word derived from the requested address.
  function automatic logic [31:0] instr_of(input logic [63:0] addr);
    return addr[31:0] ^ 32'h0000_0013;
  endfunction

  assign iresp_data = instr_of(ireq_addr);

  task automatic applyStimulus(input logic rst, input logic ok, input logic rv,
                               input logic [63:0] rpc, input logic cf,
                               input logic [63:0] cpc, input logic rdy);
    reset          = rst;
    iresp_ok       = ok;
    redirect_valid = rv;
    redirect_pc    = rpc;
    csr_flush      = cf;
    csr_pc         = cpc;
    out_ready      = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count = check_count + 1;
    if (observed === expected) begin
      pass_count = pass_count + 1;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pass_count  = 0;
    check_count = 0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    step();
    checkOutput("rst_out_valid", {63'h0, out_valid}, 64'h0);
    checkOutput("rst_ireq_valid", {63'h0, ireq_valid}, 64'h0);
    checkOutput("rst_out_pc", out_pc, 64'h0);
    checkOutput("rst_out_instr", {32'h0, out_instr}, 64'h0);

    // Streaming at one instruction per cycle
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    step();
    checkOutput("s_addr0", ireq_addr, 64'h8000_0000);
    checkOutput("s_req0", {63'h0, ireq_valid}, 64'h1);
    checkOutput("s_ov0", {63'h0, out_valid}, 64'h0);
    step();
    checkOutput("s_addr1", ireq_addr, 64'h8000_0004);
    checkOutput("s_ov1", {63'h0, out_valid}, 64'h1);
    checkOutput("s_opc1", out_pc, 64'h8000_0000);
    checkOutput("s_oin1", {32'h0, out_instr}, {32'h0, instr_of(64'h8000_0000)});
    step();
    checkOutput("s_addr2", ireq_addr, 64'h8000_0008);
    checkOutput("s_opc2", out_pc, 64'h8000_0004);

    // Backpressure into HOLD, then release
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    step();
    step();
    checkOutput("h_opc0", out_pc, 64'h8000_0000);
    checkOutput("h_addr0", ireq_addr, 64'h8000_0004);
    step();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("h_req_%0d", i), {63'h0, ireq_valid}, 64'h0);
      checkOutput($sformatf("h_opc_%0d", i), out_pc, 64'h8000_0000);
      if (i < 4) step();
    end
    out_ready = 1'b1;
    step();
    checkOutput("h_rel_opc", out_pc, 64'h8000_0004);
    checkOutput("h_rel_oin", {32'h0, out_instr}, {32'h0, instr_of(64'h8000_0004)});
    checkOutput("h_rel_req", {63'h0, ireq_valid}, 64'h1);
    checkOutput("h_rel_addr", ireq_addr, 64'h8000_0008);
    step();
    checkOutput("h_next_opc", out_pc, 64'h8000_0008);
    checkOutput("h_next_addr", ireq_addr, 64'h8000_000C);

    // Redirect while a request is pending
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    step();
    iresp_ok = 1'b1;
    step();
    checkOutput("r_addr_pend", ireq_addr, 64'h8000_0004);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_1001, 1'b0, 64'h0, 1'b1);
    step();
    redirect_valid = 1'b0;
    checkOutput("r_kill_addr0", ireq_addr, 64'h8000_0004);
    checkOutput("r_kill_req0", {63'h0, ireq_valid}, 64'h1);
    checkOutput("r_kill_ov0", {63'h0, out_valid}, 64'h0);
    step();
    checkOutput("r_kill_addr1", ireq_addr, 64'h8000_0004);
    step();
    checkOutput("r_kill_addr2", ireq_addr, 64'h8000_0004);
    iresp_ok = 1'b1;
    step();
    checkOutput("r_new_addr", ireq_addr, 64'h8000_1000);
    checkOutput("r_stale_ov", {63'h0, out_valid}, 64'h0);
    step();
    checkOutput("r_new_ov", {63'h0, out_valid}, 64'h1);
    checkOutput("r_new_opc", out_pc, 64'h8000_1000);

    // CSR flush beats a coincident execute redirect
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h8000_3000, 1'b1, 64'h8000_2000, 1'b1);
    step();
    checkOutput("c_addr", ireq_addr, 64'h8000_2000);
    checkOutput("c_ov", {63'h0, out_valid}, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    step();
    checkOutput("c_opc", out_pc, 64'h8000_2000);
    checkOutput("c_ov2", {63'h0, out_valid}, 64'h1);

    // Two redirects in KILL, the second coincident with the response
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_4000, 1'b0, 64'h0, 1'b1);
    step();
    checkOutput("k_addr_old", ireq_addr, 64'h8000_2004);
    checkOutput("k_ov0", {63'h0, out_valid}, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h8000_5000, 1'b0, 64'h0, 1'b1);
    step();
    checkOutput("k_addr_new", ireq_addr, 64'h8000_5000);
    checkOutput("k_ov1", {63'h0, out_valid}, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    step();
    checkOutput("k_opc", out_pc, 64'h8000_5000);
    checkOutput("k_oin", {32'h0, out_instr}, {32'h0, instr_of(64'h8000_5000)});

    // Reset in the middle of HOLD
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    step();
    step();
    step();
    checkOutput("x_hold_req", {63'h0, ireq_valid}, 64'h0);
    checkOutput("x_hold_ov", {63'h0, out_valid}, 64'h1);
    reset = 1'b1;
    step();
    checkOutput("x_rst_ov", {63'h0, out_valid}, 64'h0);
    checkOutput("x_rst_req", {63'h0, ireq_valid}, 64'h0);
    checkOutput("x_rst_opc", out_pc, 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    step();
    checkOutput("x_restart_addr", ireq_addr, 64'h8000_0000);
    checkOutput("x_restart_req", {63'h0, ireq_valid}, 64'h1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
